// File: rtl/alu8_pkg.sv
// Shared types and constants for the 8-bit ALU operand feed stage.
package alu8_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_OP_W  = 3;

  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_NOT = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd5;

  typedef enum logic [0:0] {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]  op;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
  } entry_t;

endpackage

// File: rtl/operand_fifo.sv
// Circular-buffer FIFO with a registered head entry (first-word fall-through).
module operand_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 19,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    head_q, head_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (cnt_q == LVL_W'(DEPTH));
  assign empty     = (cnt_q == {LVL_W{1'b0}});
  assign level     = cnt_q;
  assign dout      = head_q;
  assign push_ok_s = push && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;

  // Next pointers, occupancy and head entry; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {LVL_W{1'b0}};
      head_d   = {DW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + LVL_W'(1);
        2'b01:   cnt_d = cnt_q - LVL_W'(1);
        default: cnt_d = cnt_q;
      endcase
      // Head keeps the last popped entry when the FIFO drains empty.
      if (pop_ok_s) begin
        if (cnt_q > LVL_W'(1)) begin
          head_d = mem_q[rd_ptr_q + PTR_W'(1)];
        end else if (push_ok_s) begin
          head_d = din;
        end else begin
          head_d = head_q;
        end
      end else if (push_ok_s && empty) begin
        head_d = din;
      end else begin
        head_d = head_q;
      end
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {LVL_W{1'b0}};
      head_q   <= {DW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Assembles byte-serial {A+op, B} beats into operand triples and queues them
// for the ALU datapath behind a valid/ready handshake.
module alu_operand_stage
  import alu8_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = ALU_OP_W,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [OP_W-1:0]              in_op,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_a,
  output logic [WIDTH-1:0]             out_b,
  output logic [OP_W-1:0]              out_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int ENTRY_W = OP_W + 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_hold_q, a_hold_d;
  logic [OP_W-1:0]    op_hold_q, op_hold_d;
  logic               full_s, empty_s, beat_s, push_s;
  logic [ENTRY_W-1:0] din_s, dout_s;

  // Ready depends only on registered state, never on out_ready.
  always_comb begin
    case (state_q)
      WAIT_A:  in_ready = 1'b1;
      WAIT_B:  in_ready = !full_s;
      default: in_ready = 1'b0;
    endcase
  end

  assign beat_s = in_valid && in_ready && !flush;
  assign din_s  = {op_hold_q, a_hold_q, in_data};

  // Beat assembler next-state logic.
  always_comb begin
    state_d   = state_q;
    a_hold_d  = a_hold_q;
    op_hold_d = op_hold_q;
    push_s    = 1'b0;
    if (flush) begin
      state_d   = WAIT_A;
      a_hold_d  = {WIDTH{1'b0}};
      op_hold_d = {OP_W{1'b0}};
    end else begin
      case (state_q)
        WAIT_A: begin
          if (beat_s) begin
            a_hold_d  = in_data;
            op_hold_d = in_op;
            state_d   = WAIT_B;
          end else begin
            state_d   = WAIT_A;
          end
        end
        WAIT_B: begin
          if (beat_s) begin
            push_s  = 1'b1;
            state_d = WAIT_A;
          end else begin
            state_d = WAIT_B;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  // Assembler state and hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_A;
      a_hold_q  <= {WIDTH{1'b0}};
      op_hold_q <= {OP_W{1'b0}};
    end else begin
      state_q   <= state_d;
      a_hold_q  <= a_hold_d;
      op_hold_q <= op_hold_d;
    end
  end

  operand_fifo #(
    .DEPTH (DEPTH),
    .DW    (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push_s),
    .pop   (out_ready),
    .din   (din_s),
    .dout  (dout_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  assign {out_op, out_a, out_b} = dout_s;
  assign out_valid              = !empty_s;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Table-driven plus scoreboard bench for alu_operand_stage.
module tb_alu_operand_stage;
  import alu8_pkg::*;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic [2:0] in_op;
  logic       in_ready, out_valid;
  logic [7:0] out_a, out_b;
  logic [2:0] out_op;
  logic [1:0] level;

  alu_operand_stage #(.WIDTH(8), .OP_W(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_op(in_op),
    .in_valid(in_valid), .in_ready(in_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_valid(out_valid), .out_ready(out_ready), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int         rdy;   // 0/1 fixed out_ready, 2 random
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  entry_t     sb[$];
  bit         exp_b = 1'b0;
  logic [7:0] hold_a = 8'h00;
  logic [2:0] hold_op = 3'd0;
  bit         accepted;
  vec_t       vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare outputs mid-cycle, then advance the reference model across the edge.
  task automatic tick();
    logic exp_rdy;
    bit   popv;
    @(negedge clk);
    exp_rdy = !exp_b || (sb.size() < DEPTH);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, sb.size() != 0);
    chk("level", level, sb.size());
    if (sb.size() != 0) begin
      chk("out_a", out_a, sb[0].a);
      chk("out_b", out_b, sb[0].b);
      chk("out_op", out_op, sb[0].op);
    end
    accepted = in_valid && exp_rdy && !flush;
    if (flush) begin
      sb.delete();
      exp_b = 1'b0;
    end else begin
      popv = out_ready && (sb.size() != 0);
      if (popv) void'(sb.pop_front());
      if (accepted) begin
        if (!exp_b) begin
          hold_a  = in_data;
          hold_op = in_op;
          exp_b   = 1'b1;
        end else begin
          sb.push_back('{op: hold_op, a: hold_a, b: in_data});
          exp_b = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [2:0] op, input int rdy);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    accepted = 1'b0;
    for (int n = 0; n < 50; n++) begin
      out_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
      tick();
      if (accepted) break;
    end
    if (!accepted) begin
      failures++;
      $display("FAIL beat_timeout data=%0h not accepted within 50 cycles", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    tick();
    chk("drained_level", level, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; in_op = 3'd0;

    vecs[0] = '{a: 8'hF0, b: 8'h3C, op: OP_AND, rdy: 1};
    for (int i = 0; i < 10; i++)
      vecs[i+1] = '{a: 8'(i), b: ~8'(i), op: 3'(i % 6), rdy: 2};

    #12;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_op", out_op, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic transfer followed by wrap-around stream with random backpressure.
    for (int i = 0; i < 11; i++) begin
      send_beat(vecs[i].a, vecs[i].op, vecs[i].rdy);
      send_beat(vecs[i].b, 3'd7, vecs[i].rdy);
      if (i == 0) chk("basic_level_after_b", level, 1);
    end
    drain();

    // Backpressure: two triples fill the FIFO, third stalls in WAIT_B.
    send_beat(8'h01, OP_OR, 0);  send_beat(8'h02, OP_OR, 0);
    send_beat(8'h03, OP_XOR, 0); send_beat(8'h04, OP_XOR, 0);
    chk("bp_level_full", level, 2);
    send_beat(8'h05, OP_SUB, 0);
    in_valid = 1'b1; in_data = 8'h06; in_op = 3'd0;
    for (int n = 0; n < 3; n++) tick();
    chk("bp_in_ready_low", in_ready, 0);
    send_beat(8'h06, 3'd0, 1);
    drain();

    // Simultaneous push and pop with one entry queued.
    send_beat(8'h21, OP_ADD, 0); send_beat(8'h22, OP_ADD, 0);
    send_beat(8'h31, OP_NOT, 0); send_beat(8'h32, OP_NOT, 1);
    chk("pushpop_level", level, 1);
    chk("pushpop_head_a", out_a, 8'h31);
    drain();

    // Flush priority over a pending beat and pop.
    send_beat(8'h12, OP_OR, 0); send_beat(8'h34, OP_OR, 0);
    send_beat(8'hAA, OP_XOR, 0);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_a", out_a, 0);
    send_beat(8'h11, OP_ADD, 1); send_beat(8'h22, OP_ADD, 1);
    drain();

    // Asynchronous reset mid-stream with FIFO full and a partial A held.
    send_beat(8'h41, OP_AND, 0); send_beat(8'h42, OP_AND, 0);
    send_beat(8'h43, OP_AND, 0); send_beat(8'h44, OP_AND, 0);
    send_beat(8'h45, OP_OR, 0);
    chk("prerst_level", level, 2);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_a", out_a, 0);
    chk("arst_out_b", out_b, 0);
    sb.delete(); exp_b = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send_beat(8'h7E, OP_SUB, 1); send_beat(8'h81, OP_SUB, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Upstream feed stage for the 8-bit ALU logic units (AND/OR/XOR/ADD…).
- Collects operands from a byte-serial input bus: beat 1 is operand A plus opcode, beat 2 is operand B.
- Queues each completed {A, B, op} triple in a small FIFO.
- Presents the FIFO head as registered in_a/in_b-style operands with a valid/ready handshake to the ALU datapath.

Parameters:
- WIDTH, 8, operand width in bits.
- OP_W, 3, opcode width in bits.
- DEPTH, 2, FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of the assembler and FIFO.
- in_data  input  WIDTH  serial operand byte.
- in_op  input  OP_W  opcode; sampled only on an A beat.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  stage accepts in_data this cycle.
- out_a  output  WIDTH  operand A of the FIFO head.
- out_b  output  WIDTH  operand B of the FIFO head.
- out_op  output  OP_W  opcode of the FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  downstream consumes the head this cycle.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async, active-high, clk and rst as the only clock/reset):
  - state = WAIT_A, FIFO empty, level = 0.
  - out_valid = 0; out_a, out_b, out_op = 0.
  - in_ready = 1; A holding register = 0; op holding register = 0.
- Handshakes:
  - Input beat transfers when in_valid && in_ready.
  - Output entry pops when out_valid && out_ready.
  - No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- FSM:
  - WAIT_A: in_ready = 1. On a beat, latch in_data→A_hold and in_op→op_hold, then go to WAIT_B.
  - WAIT_B: in_ready = !full. On a beat, push {A_hold, in_data, op_hold} into the FIFO and return to WAIT_A.
  - WAIT_B with FIFO full: in_ready = 0; A_hold and op_hold are held indefinitely.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr and an occupancy count; pointers wrap modulo DEPTH.
  - full = (level == DEPTH); empty = (level == 0).
  - out_a/out_b/out_op come directly from the head entry register (first-word fall-through). When empty they hold the last popped entry (0 after reset/flush); verification ignores them while out_valid = 0.
  - Push and pop in the same cycle: level unchanged, both pointers advance. This is legal at any non-empty level. Push when full cannot occur because in_ready gates it.
  - Pop is ignored when empty.
- Latency: a B beat accepted at edge N gives out_valid = 1 immediately after edge N, with the new entry at the head if the FIFO was empty.
- Throughput: one triple per 2 input beats sustained; the output side is never the bottleneck when out_ready = 1.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next state: WAIT_A, level = 0, pointers = 0, out_valid = 0.
  - A beat offered during the flush cycle is discarded, even though in_ready may be 1.
- Reset mid-operation: any partial A and all queued entries are lost; no output is produced for them.
- Data is passed through unmodified; no arithmetic on operands. in_op is ignored during WAIT_B beats.

Decomposition:
- Package alu8_pkg holds:
  - WIDTH and OP_W defaults.
  - Opcode constants: OP_AND = 0, OP_OR = 1, OP_XOR = 2, OP_NOT = 3, OP_ADD = 4, OP_SUB = 5.
  - FSM state enum {WAIT_A, WAIT_B}.
  - Packed entry struct {op, a, b}.
- One sub-module, operand_fifo:
  - Parameterised DEPTH and entry width.
  - Ports: push, pop, flush, din, dout, full, empty, level.
- The top module holds the FSM and the hold registers.

Test Plan:
- Basic transfer: reset; send A = 0xF0 with op = OP_AND, then B = 0x3C; out_ready = 1 → out_valid high the cycle after the B beat with out_a = 0xF0, out_b = 0x3C, out_op = 0; pops next edge; level returns to 0.
- Backpressure/full: out_ready = 0; send 3 triples (0x01/0x02, 0x03/0x04, 0x05/0x06) → level = 2 after the second triple. A = 0x05 is accepted, then in_ready = 0 in WAIT_B. Raise out_ready → entries exit in order 01/02, 03/04, 05/06 with no loss or duplication.
- Simultaneous push and pop: FIFO holding 1 entry; a B beat and a pop in the same edge → level stays 1; the head becomes the new triple.
- Pointer wrap: 10 back-to-back triples (A = i, B = ~i) with out_ready toggling on a pseudo-random pattern → all 10 observed in order; the pointers wrap at least 4 times.
- Flush priority: after A = 0xAA accepted and one entry queued, assert flush together with in_valid and out_ready → next cycle level = 0, out_valid = 0, state WAIT_A. The following beat 0x11 is treated as an A beat.
- Async reset mid-stream: assert rst between clock edges while level = 2 in WAIT_B → outputs go to reset values without waiting for a clock edge; after release, a fresh triple 0x7E/0x81 emerges alone.
